// File: rtl/lfsr_bank_pkg.sv
// Shared types and default sizing for the LFSR bank.
package lfsr_bank_pkg;

  localparam int unsigned DefWidth    = 107;
  localparam int unsigned DefChannels = 4;

  typedef enum logic [0:0] {
    StLoad,
    StRun
  } state_e;

endpackage

// File: rtl/lfsr_chan.sv
// One Galois LFSR channel: seed load, step, and (with LFSR_BANK_LOCKUP_EN) lockup recovery
// from the stored seed.
module lfsr_chan
  import lfsr_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] tap,
  output logic [WIDTH-1:0] data
`ifdef LFSR_BANK_LOCKUP_EN
  ,
  output logic             lockup
`endif
);

  logic [WIDTH-1:0] r_q, r_d, step_val;

  assign step_val = (r_q >> 1) ^ (r_q[0] ? tap : '0);
  assign data     = r_q;

`ifdef LFSR_BANK_LOCKUP_EN
  logic [WIDTH-1:0] seed_q;
  logic             lockup_q, lockup_d;

  // A load always beats a step; a step that would reach zero restarts from the stored seed.
  always_comb begin
    r_d      = r_q;
    lockup_d = 1'b0;
    if (load) begin
      r_d = seed;
    end else if (step) begin
      if (step_val == '0) begin
        r_d      = seed_q;
        lockup_d = 1'b1;
      end else begin
        r_d = step_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= '0;
      seed_q   <= '0;
      lockup_q <= 1'b0;
    end else begin
      r_q      <= r_d;
      lockup_q <= lockup_d;
      if (load) seed_q <= seed;
    end
  end

  assign lockup = lockup_q;
`else
  always_comb begin
    r_d = r_q;
    if (load) begin
      r_d = seed;
    end else if (step) begin
      r_d = step_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end
`endif

endmodule

// File: rtl/lfsr_bank.sv
// Bank of CHANNELS Galois LFSRs with a LOAD/RUN seeding FSM and a valid/ready sample stream.
// Define LFSR_BANK_LOCKUP_EN to enable per-channel lockup recovery and the lockup port.
module lfsr_bank
  import lfsr_bank_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned CHANNELS = DefChannels,
  parameter int unsigned CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      seed_valid,
  output logic                      seed_ready,
  input  logic [CW-1:0]             seed_ch,
  input  logic [WIDTH-1:0]          seed,
  input  logic [WIDTH-1:0]          tap,
  output logic                      seed_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data
`ifdef LFSR_BANK_LOCKUP_EN
  ,
  output logic [CHANNELS-1:0]       lockup
`endif
);

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] seeded_q, seeded_d, load;
  logic [31:0]         ch_ext;
  logic                seed_ok, step, seed_err_q;

  // Widened so the range check stays meaningful when CHANNELS fills the index width.
  assign ch_ext     = 32'(seed_ch);
  assign seed_ok    = seed_valid && (seed != '0) && (ch_ext < CHANNELS);
  assign seed_ready = 1'b1;
  assign out_valid  = (state_q == StRun);
  assign step       = out_valid && out_ready;
  assign seed_err   = seed_err_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign load[c] = seed_ok && (ch_ext == 32'(c));

    lfsr_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .load   (load[c]),
      .step   (step),
      .seed   (seed),
      .tap    (tap),
      .data   (out_data[c*WIDTH +: WIDTH])
`ifdef LFSR_BANK_LOCKUP_EN
      ,
      .lockup (lockup[c])
`endif
    );
  end

  always_comb begin
    seeded_d = seeded_q | load;
    state_d  = state_q;
    if (state_q == StLoad && (&seeded_d)) begin
      state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoad;
      seeded_q   <= '0;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seeded_q   <= seeded_d;
      seed_err_q <= seed_valid && !seed_ok;
    end
  end

endmodule

// File: tb/tb_lfsr_bank.sv
// Scoreboarded bench for lfsr_bank (WIDTH=8, CHANNELS=2, CW=2 so out-of-range channels exist).
module tb_lfsr_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_valid = 1'b0;
  logic        seed_ready;
  logic [1:0]  seed_ch = '0;
  logic [7:0]  seed = '0;
  logic [7:0]  tap = 8'hB8;
  logic        seed_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
`ifdef LFSR_BANK_LOCKUP_EN
  logic [1:0]  lockup;
`endif

  lfsr_bank #(
    .WIDTH    (8),
    .CHANNELS (2),
    .CW       (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .seed_ch    (seed_ch),
    .seed       (seed),
    .tap        (tap),
    .seed_err   (seed_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef LFSR_BANK_LOCKUP_EN
    ,
    .lockup     (lockup)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];

  // Reference model: channel values, stored seeds, seeded flags, running flag.
  logic [7:0] m_reg[2];
  logic [7:0] m_seed[2];
  logic       m_seeded[2];
  logic       m_run;
  logic       m_err;
  logic [1:0] m_lock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] galois(input logic [7:0] r, input logic [7:0] t);
    return (r / 2) ^ ((r % 2 == 1) ? t : 8'h00);
  endfunction

  // One clock: drive inputs, predict, advance model across the edge, check registered outputs.
  task automatic cyc(input logic r, input logic sv, input logic [1:0] ch, input logic [7:0] sd,
                     input logic ordy, input logic [7:0] tp);
    logic [7:0] nr[2];
    logic [7:0] ns[2];
    logic       nseed[2];
    logic [1:0] nlock;
    logic       acc, hs;
    rst = r; seed_valid = sv; seed_ch = ch; seed = sd; out_ready = ordy; tap = tp;
    if (m_run && ordy) exp_q.push_back({m_reg[1], m_reg[0]});
    acc = sv && (sd != 0) && (ch < 2);
    hs  = m_run && ordy;
    nlock = '0;
    for (int c = 0; c < 2; c++) begin
      nr[c] = m_reg[c]; ns[c] = m_seed[c]; nseed[c] = m_seeded[c];
      if (acc && ch == c) begin
        nr[c] = sd; ns[c] = sd; nseed[c] = 1'b1;
      end else if (hs) begin
        nr[c] = galois(m_reg[c], tp);
`ifdef LFSR_BANK_LOCKUP_EN
        if (nr[c] == 0) begin
          nr[c] = m_seed[c]; nlock[c] = 1'b1;
        end
`endif
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        m_reg[c] = '0; m_seed[c] = '0; m_seeded[c] = 1'b0;
      end
      m_run = 1'b0; m_err = 1'b0; m_lock = '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_reg[c] = nr[c]; m_seed[c] = ns[c]; m_seeded[c] = nseed[c];
      end
      m_err  = sv && !acc;
      m_lock = nlock;
      m_run  = m_run || (m_seeded[0] && m_seeded[1]);
    end
    chk("seed_err", 32'(seed_err), 32'(m_err));
    chk("out_valid", 32'(out_valid), 32'(m_run));
    chk("seed_ready", 32'(seed_ready), 32'd1);
`ifdef LFSR_BANK_LOCKUP_EN
    chk("lockup", 32'(lockup), 32'(m_lock));
`endif
  endtask

  // Monitor: every accepted sample must match the oldest predicted sample.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sample_unexpected got=%h exp=none", out_data);
      end else begin
        chk("sample", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  logic [7:0] seq0[6];
  logic [7:0] seq1[6];

  initial begin
    logic [7:0] t_cur;
    seq0[0] = 8'h01; seq0[1] = 8'hB8; seq0[2] = 8'h5C;
    seq0[3] = 8'h2E; seq0[4] = 8'h17; seq0[5] = 8'hB3;
    seq1[0] = 8'h80; seq1[1] = 8'h40; seq1[2] = 8'h20;
    seq1[3] = 8'h10; seq1[4] = 8'h08; seq1[5] = 8'h04;
    m_run = 1'b0; m_err = 1'b0; m_lock = '0;
    for (int c = 0; c < 2; c++) begin
      m_reg[c] = '0; m_seed[c] = '0; m_seeded[c] = 1'b0;
    end

    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 8'hB8);
    cyc(1, 0, 0, 0, 0, 8'hB8);
    chk("reset_data", 32'(out_data), 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);

    // Rejected seeds: zero value and out-of-range channel.
    cyc(0, 1, 0, 8'h00, 1, 8'hB8);
    chk("err_zero_seed", 32'(seed_err), 32'h1);
    cyc(0, 1, 2, 8'h55, 1, 8'hB8);
    chk("err_bad_ch", 32'(seed_err), 32'h1);
    chk("err_no_load", 32'(out_data), 32'h0);
    cyc(0, 0, 0, 0, 1, 8'hB8);
    chk("err_one_cycle", 32'(seed_err), 32'h0);

    // Partial seeding stays in LOAD; the last seed enters RUN with the seeds as first sample.
    cyc(0, 1, 0, 8'h01, 1, 8'hB8);
    chk("partial_not_valid", 32'(out_valid), 32'h0);
    cyc(0, 1, 1, 8'h80, 1, 8'hB8);
    chk("run_entry_valid", 32'(out_valid), 32'h1);
    for (int i = 0; i < 6; i++) begin
      chk("known_sequence", 32'(out_data), 32'({seq1[i], seq0[i]}));
      if (i < 5) cyc(0, 0, 0, 0, 1, 8'hB8);
    end

    // Stall: output must hold, then resume with the next value.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 8'hB8);
      chk("stall_hold", 32'(out_data), 32'h04B3);
    end
    cyc(0, 0, 0, 0, 1, 8'hB8);
    chk("stall_resume", 32'(out_data), 32'h02E1);

    // Reseed colliding with a handshake: seed wins on ch0, ch1 still steps.
    cyc(0, 1, 0, 8'h01, 1, 8'hB8);
    chk("reseed_collide", 32'(out_data), 32'h0101);

    // Reset mid-stream abandons the stream.
    cyc(1, 0, 0, 0, 1, 8'hB8);
    chk("midreset_valid", 32'(out_valid), 32'h0);
    chk("midreset_data", 32'(out_data), 32'h0);

    // Step that lands on zero.
    cyc(0, 1, 0, 8'h81, 0, 8'h40);
    cyc(0, 1, 1, 8'h01, 0, 8'h40);
    cyc(0, 0, 0, 0, 1, 8'h40);
`ifdef LFSR_BANK_LOCKUP_EN
    chk("lockup_reload", 32'(out_data[7:0]), 32'h81);
    chk("lockup_pulse", 32'(lockup[0]), 32'h1);
`else
    chk("zero_loaded", 32'(out_data[7:0]), 32'h00);
`endif

    // Randomized traffic, including bad seeds, stalls, tap changes and resets.
    t_cur = 8'hB8;
    for (int i = 0; i < 1500; i++) begin
      logic       r, sv, ordy;
      logic [1:0] ch;
      logic [7:0] sd;
      if ($urandom_range(0, 19) == 0) t_cur = 8'($urandom);
      r    = ($urandom_range(0, 149) == 0);
      sv   = ($urandom_range(0, 3) == 0);
      ch   = 2'($urandom_range(0, 2));
      sd   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      cyc(r, sv, ch, sd, ordy, t_cur);
      if (m_run) chk("rand_data", 32'(out_data), 32'({m_reg[1], m_reg[0]}));
    end

    cyc(0, 0, 0, 0, 0, t_cur);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_bank.md
LFSR_BANK -- requirements
Module: lfsr_bank

Interface
- REQ-001 SHALL have parameter WIDTH, default 107: LFSR register width in bits, legal range 4..256.
- REQ-002 SHALL have parameter CHANNELS, default 4: number of independent LFSR channels, legal range 1..16.
- REQ-003 SHALL have parameter CW, default max(1, clog2(CHANNELS)): width of the channel index.
- REQ-004 clk  in  1  clock; all logic is on the rising edge.
- REQ-005 rst  in  1  reset, synchronous, active-high.
- REQ-006 seed_valid  in  1  seed write request.
- REQ-007 seed_ready  out  1  seed write accepted this cycle.
- REQ-008 seed_ch  in  CW  target channel of the seed write.
- REQ-009 seed  in  WIDTH  seed value.
- REQ-010 tap  in  WIDTH  Galois tap mask, shared by all channels, sampled every step.
- REQ-011 seed_err  out  1  one-cycle pulse: zero seed or out-of-range channel rejected.
- REQ-012 out_valid  out  1  out_data holds a valid sample.
- REQ-013 out_ready  in  1  consumer accepts the sample.
- REQ-014 out_data  out  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].

Function
- REQ-015 SHALL use a two-state FSM: LOAD, then RUN.
- REQ-016 In LOAD: seed_ready=1 and out_valid=0; each accepted seed sets that channel's seeded flag.
- REQ-017 LOAD->RUN on the clock edge after which all seeded flags are 1.
- REQ-018 In RUN: out_valid=1, and seed_ready=1 so a live reseed is allowed.
- REQ-019 SHALL accept a seed only when seed_valid=1, seed!=0 and seed_ch<CHANNELS.
- REQ-020 An accepted seed loads that channel's register and its stored-seed copy on the next edge.
- REQ-021 If seed_valid=1 and the seed is zero or the channel is out of range: nothing is loaded and seed_err pulses 1 on the next cycle.
- REQ-022 Step (per channel, register r): fb=r[0]; next = (r>>1) XOR (fb ? tap : 0).
- REQ-023 All channels SHALL step together, exactly on cycles where out_valid&&out_ready; otherwise they hold.
- REQ-024 The first sample output after RUN entry SHALL be the seeds themselves; each handshake exposes the next step on the following cycle (one step per accepted sample, zero-bubble).
- REQ-025 If a seed write and a step hit the same channel in the same cycle, the seed SHALL win for that channel; the other channels still step.
- REQ-026 Back-to-back seed writes to the same channel: the last accepted write wins.

Reset
- REQ-027 On rst: FSM=LOAD; all registers, stored seeds and seeded flags=0; seed_err=0; out_valid=0; seed_ready=1 from the first cycle after reset.
- REQ-028 rst asserted mid-stream SHALL abandon the current sample without completing the handshake.

Configuration
- REQ-029 Macro LFSR_BANK_LOCKUP_EN SHALL control lockup recovery.
- REQ-030 With LFSR_BANK_LOCKUP_EN defined: a step whose next value is 0 SHALL load that channel's stored seed instead. A one-cycle output lockup[CHANNELS] bit SHALL pulse for that channel.
- REQ-031 Without LFSR_BANK_LOCKUP_EN: the lockup port is absent, stored-seed registers are absent, and a zero next value is loaded as-is.

Structure
- REQ-032 Package lfsr_bank_pkg SHALL hold the FSM state enum and the default WIDTH/CHANNELS constants.
- REQ-033 Sub-module lfsr_chan SHALL hold one channel's register, stored seed, load/step muxing and lockup detection; the top instantiates CHANNELS copies plus the FSM and handshake logic.

Verification (WIDTH=8, CHANNELS=2, tap=8'hB8 unless stated)
- REQ-034 Seed ch0=8'h01, ch1=8'h80, out_ready=1 -> ch0 samples 01,B8,5C,2E,17,B3; ch1 samples 80,40,20,10,08,04.
- REQ-035 Seed only ch0 -> out_valid stays 0; then seed ch1 -> out_valid=1 on the next cycle.
- REQ-036 seed=8'h00, or seed_ch=2 -> seed_err pulses once, no state change, FSM stays LOAD.
- REQ-037 In RUN, out_ready low for 5 cycles -> out_data stable. Then out_ready high -> sequence resumes with no skipped value.
- REQ-038 In RUN, reseed ch0=8'h01 in the same cycle as a handshake -> next ch0 sample=01 and ch1 has stepped.
- REQ-039 With LFSR_BANK_LOCKUP_EN, tap=8'h40, seed 8'h81 -> after one step ch0 reads 81, lockup[0] pulses; without the macro -> ch0 reads 00.
